// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares one registered common data bus among several
// functional units. Each source has a small FIFO. One head is granted per
// cycle in round-robin order from rr_ptr.
module cdb_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 3,
  parameter int QDEPTH  = 2,
  localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*DATA_W-1:0] src_val,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
  output logic [NUM_SRC-1:0]        src_full,
  output logic                      cdb_valid,
  output logic [DATA_W-1:0]         cdb_val,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [SRC_W-1:0]          cdb_src,
  output logic                      overflow
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = $clog2(QDEPTH + 1);

  logic [DATA_W-1:0] q_val  [NUM_SRC][QDEPTH];
  logic [TAG_W-1:0]  q_tag  [NUM_SRC][QDEPTH];
  logic [PTR_W-1:0]  rd_ptr [NUM_SRC];
  logic [PTR_W-1:0]  wr_ptr [NUM_SRC];
  logic [CNT_W-1:0]  count  [NUM_SRC];

  logic [SRC_W-1:0]   rr_ptr;
  logic [SRC_W-1:0]   winner;
  logic [SRC_W-1:0]   scan_idx;
  logic               grant;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] drop;

  // Pick the first non-empty queue scanning upward from rr_ptr, with wrap.
  always_comb begin
    grant    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      scan_idx = SRC_W'((int'(rr_ptr) + k) % NUM_SRC);
      if (!grant && (count[scan_idx] != '0)) begin
        grant  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  // Per-queue pop/push/drop decisions. A full queue still accepts a push
  // when it is popped on the same edge.
  always_comb begin
    pop      = '0;
    push     = '0;
    drop     = '0;
    src_full = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pop[i]      = grant && (winner == SRC_W'(i));
      src_full[i] = (count[i] == CNT_W'(QDEPTH));
      push[i]     = src_valid[i] && (!src_full[i] || pop[i]);
      drop[i]     = src_valid[i] && src_full[i] && !pop[i];
    end
  end

  // Queue storage; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (!reset && !flush) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push[i]) begin
          q_val[i][wr_ptr[i]] <= src_val[i*DATA_W +: DATA_W];
          q_tag[i][wr_ptr[i]] <= src_tag[i*TAG_W +: TAG_W];
        end
      end
    end
  end

  // Queue bookkeeping, round-robin pointer, registered CDB and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      rr_ptr    <= '0;
      cdb_valid <= 1'b0;
      cdb_val   <= '0;
      cdb_tag   <= '0;
      cdb_src   <= '0;
      overflow  <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        count[i]  <= '0;
      end
      cdb_valid <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
      if (|drop) overflow <= 1'b1;
      if (grant) begin
        cdb_valid <= 1'b1;
        cdb_val   <= q_val[winner][rd_ptr[winner]];
        cdb_tag   <= q_tag[winner][rd_ptr[winner]];
        cdb_src   <= winner;
        rr_ptr    <= (winner == SRC_W'(NUM_SRC - 1)) ? '0 : winner + SRC_W'(1);
      end else begin
        cdb_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with two sources and two-entry queues.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [1:0]  src_valid;
  logic [63:0] src_val;
  logic [5:0]  src_tag;
  logic [1:0]  src_full;
  logic        cdb_valid;
  logic [31:0] cdb_val;
  logic [2:0]  cdb_tag;
  logic [0:0]  cdb_src;
  logic        overflow;

  int assertions = 0;
  int failures   = 0;

  cdb_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .src_valid (src_valid),
    .src_val   (src_val),
    .src_tag   (src_tag),
    .src_full  (src_full),
    .cdb_valid (cdb_valid),
    .cdb_val   (cdb_val),
    .cdb_tag   (cdb_tag),
    .cdb_src   (cdb_src),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    assertions++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // One clock edge; outputs are sampled 1 ns later and pulses are cleared.
  task automatic tick();
    @(posedge clk);
    #1;
    src_valid = '0;
    flush     = 1'b0;
  endtask

  task automatic drive(input int s, input logic [31:0] v, input logic [2:0] t);
    src_valid[s]       = 1'b1;
    src_val[s*32 +: 32] = v;
    src_tag[s*3 +: 3]   = t;
  endtask

  task automatic grant_is(input string name, input logic [31:0] v, input logic [2:0] t,
                          input logic s);
    chk({name, "_valid"}, cdb_valid, 1'b1);
    chk({name, "_val"},   cdb_val,   v);
    chk({name, "_tag"},   cdb_tag,   t);
    chk({name, "_src"},   cdb_src,   s);
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    src_valid = '0;
    src_val   = '0;
    src_tag   = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_valid", cdb_valid, 1'b0);
    chk("rst_val",   cdb_val,   32'h0);
    chk("rst_tag",   cdb_tag,   3'd0);
    chk("rst_src",   cdb_src,   1'b0);
    chk("rst_ovf",   overflow,  1'b0);
    chk("rst_full",  src_full,  2'b00);

    // Single source, one-cycle latency, outputs held afterwards
    drive(0, 32'h7, 3'd3);
    tick();
    chk("single_e0_valid", cdb_valid, 1'b0);
    tick();
    grant_is("single_e1", 32'h7, 3'd3, 1'b0);
    tick();
    chk("single_e2_valid", cdb_valid, 1'b0);
    chk("single_e2_val",   cdb_val,   32'h7);
    chk("single_e2_tag",   cdb_tag,   3'd3);

    // Re-establish rr_ptr=0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst2_val", cdb_val, 32'h0);
    chk("rst2_tag", cdb_tag, 3'd0);

    // Collision from rr_ptr=0
    drive(0, 32'd5,  3'd1);
    drive(1, 32'd42, 3'd2);
    tick();
    tick();
    grant_is("coll_e1", 32'd5, 3'd1, 1'b0);
    tick();
    grant_is("coll_e2", 32'd42, 3'd2, 1'b1);
    tick();
    chk("coll_idle", cdb_valid, 1'b0);

    // Fairness: six grants alternating 0,1,0,1,0,1 with per-source order kept
    drive(0, 32'h101, 3'd1); drive(1, 32'h204, 3'd4);
    tick();
    drive(0, 32'h102, 3'd2); drive(1, 32'h205, 3'd5);
    tick();
    grant_is("fair1", 32'h101, 3'd1, 1'b0);
    drive(0, 32'h103, 3'd3); drive(1, 32'h206, 3'd6);
    tick();
    grant_is("fair2", 32'h204, 3'd4, 1'b1);
    chk("fair2_full", src_full, 2'b11);
    tick();
    grant_is("fair3", 32'h102, 3'd2, 1'b0);
    chk("fair3_full", src_full, 2'b10);
    tick();
    grant_is("fair4", 32'h205, 3'd5, 1'b1);
    chk("fair4_full", src_full, 2'b00);
    tick();
    grant_is("fair5", 32'h103, 3'd3, 1'b0);
    tick();
    grant_is("fair6", 32'h206, 3'd6, 1'b1);
    tick();
    chk("fair_idle", cdb_valid, 1'b0);

    // Back-pressure and overflow on source 1
    drive(0, 32'h111, 3'd1); drive(1, 32'h214, 3'd4);
    tick();
    chk("bp_a_valid", cdb_valid, 1'b0);
    chk("bp_a_full",  src_full,  2'b00);
    drive(0, 32'h112, 3'd2); drive(1, 32'h215, 3'd5);
    tick();
    grant_is("bp_b", 32'h111, 3'd1, 1'b0);
    chk("bp_b_full", src_full, 2'b10);
    drive(1, 32'h216, 3'd6);
    tick();
    grant_is("bp_c", 32'h214, 3'd4, 1'b1);
    chk("bp_c_full", src_full, 2'b10);
    chk("bp_c_ovf",  overflow, 1'b0);
    drive(1, 32'h217, 3'd7);
    tick();
    grant_is("bp_d", 32'h112, 3'd2, 1'b0);
    chk("bp_d_ovf",  overflow, 1'b1);
    chk("bp_d_full", src_full, 2'b10);
    tick();
    grant_is("bp_e", 32'h215, 3'd5, 1'b1);
    chk("bp_e_full", src_full, 2'b00);
    tick();
    grant_is("bp_f", 32'h216, 3'd6, 1'b1);
    tick();
    chk("bp_g_valid", cdb_valid, 1'b0);
    chk("bp_g_tag",   cdb_tag,   3'd6);

    // Flush with two entries in source 0 and one in source 1
    drive(0, 32'h121, 3'd1); drive(1, 32'h224, 3'd4);
    tick();
    drive(0, 32'h122, 3'd2); drive(1, 32'h225, 3'd5);
    tick();
    grant_is("fl_b", 32'h121, 3'd1, 1'b0);
    drive(0, 32'h123, 3'd3);
    tick();
    grant_is("fl_c", 32'h224, 3'd4, 1'b1);
    chk("fl_c_full", src_full, 2'b01);
    flush = 1'b1;
    drive(0, 32'h12f, 3'd7); drive(1, 32'h22f, 3'd7);
    tick();
    chk("fl_d_valid", cdb_valid, 1'b0);
    chk("fl_d_full",  src_full,  2'b00);
    chk("fl_d_ovf",   overflow,  1'b1);
    chk("fl_d_tag",   cdb_tag,   3'd4);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("fl_after_valid", cdb_valid, 1'b0);
    end
    drive(1, 32'h226, 3'd6);
    tick();
    tick();
    grant_is("fl_new", 32'h226, 3'd6, 1'b1);
    tick();
    chk("fl_new_idle", cdb_valid, 1'b0);

    // Reset mid-operation
    drive(0, 32'h131, 3'd1); drive(1, 32'h232, 3'd2);
    tick();
    drive(0, 32'h133, 3'd3);
    tick();
    grant_is("mr_k", 32'h131, 3'd1, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_valid", cdb_valid, 1'b0);
    chk("mr_val",   cdb_val,   32'h0);
    chk("mr_tag",   cdb_tag,   3'd0);
    chk("mr_src",   cdb_src,   1'b0);
    chk("mr_ovf",   overflow,  1'b0);
    chk("mr_full",  src_full,  2'b00);
    tick();
    chk("mr_quiet", cdb_valid, 1'b0);
    drive(0, 32'h135, 3'd5); drive(1, 32'h236, 3'd6);
    tick();
    tick();
    grant_is("mr_new0", 32'h135, 3'd5, 1'b0);
    tick();
    grant_is("mr_new1", 32'h236, 3'd6, 1'b1);
    tick();
    chk("mr_idle", cdb_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
